// File: rtl/FA.sv
// One-bit full adder cell; the only arithmetic datapath element of the serial adder.
module FA (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one FA cell,
// carry is held in a flip-flop, and the result is published as a registered word.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             last;

    FA u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (cnt == LAST);

    // The accumulator holds only the WIDTH-1 low sum bits; the final bit comes
    // straight from the FA on the completion edge, so WIDTH=1 needs no accumulator.
    if (WIDTH == 1) begin : g_no_acc
        assign result = fa_sum;
    end else begin : g_acc
        logic [WIDTH-2:0] acc;
        logic [WIDTH-2:0] acc_next;

        if (WIDTH == 2) begin : g_w2
            assign acc_next = fa_sum;
        end else begin : g_wn
            assign acc_next = {fa_sum, acc[WIDTH-2:1]};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc <= '0;
            end else if (state == RUN) begin
                acc <= acc_next;
            end
        end

        assign result = {fa_sum, acc};
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = start ? RUN : IDLE;
            RUN:     next_state = last ? DONE : RUN;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == RUN);
            done  <= (next_state == DONE);
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                carry <= fa_cout;
                cnt   <= cnt + CW'(1);
            end
            if (last) begin
                sum  <= result;
                cout <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a WIDTH=8 and a WIDTH=1 instance share clock and reset.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int tests = 0;
    int fails = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Results are popped from the scoreboard whenever a done pulse is observed.
    always @(negedge clk) begin
        logic [8:0] e8;
        logic [1:0] e1;
        if (done8 === 1'b1) begin
            tests++;
            if (q8.size() == 0) begin
                fails++;
                $display("FAIL sb8_unexpected_done: got cout/sum %b/%h, required no done pulse", cout8, sum8);
            end else begin
                e8 = q8.pop_front();
                if ({cout8, sum8} !== e8) begin
                    fails++;
                    $display("FAIL sb8_result: got %b/%h, required %b/%h", cout8, sum8, e8[8], e8[7:0]);
                end
            end
        end
        if (done1 === 1'b1) begin
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL sb1_unexpected_done: got cout/sum %b/%b, required no done pulse", cout1, sum1);
            end else begin
                e1 = q1.pop_front();
                if ({cout1, sum1} !== e1) begin
                    fails++;
                    $display("FAIL sb1_result: got %b/%b, required %b/%b", cout1, sum1, e1[1], e1[0]);
                end
            end
        end
    end

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        if (push) q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drive1(input logic a, input logic b, input logic c);
        start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        q1.push_back({1'b0, a} + {1'b0, b} + {1'b0, c});
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_done8(output int busy_cycles, output int lat, output bit seen);
        busy_cycles = 0; lat = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done8 === 1'b1) begin
                seen = 1;
                break;
            end
            if (busy8 === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done1(output int busy_cycles, output bit seen);
        busy_cycles = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done1 === 1'b1) begin
                seen = 1;
                break;
            end
            if (busy1 === 1'b1) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({busy8, done8, cout8, sum8} !== 11'b0) begin
            fails++;
            $display("FAIL reset_w8: got busy/done/cout/sum %b/%b/%b/%h, required 0/0/0/00", busy8, done8, cout8, sum8);
        end
        tests++;
        if ({busy1, done1, cout1, sum1} !== 4'b0) begin
            fails++;
            $display("FAIL reset_w1: got busy/done/cout/sum %b/%b/%b/%b, required 0/0/0/0", busy1, done1, cout1, sum1);
        end
    endtask

    task automatic test_single(input logic [7:0] a, input logic [7:0] b, input logic c, input string name);
        int bc, lat;
        bit seen;
        drive8(a, b, c, 1);
        wait_done8(bc, lat, seen);
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_timeout: got no done within 40 cycles, required done", name);
        end
        tests++;
        if (bc != 8 || lat != 8) begin
            fails++;
            $display("FAIL %s_timing: got busy %0d cycles latency %0d, required 8 and 8", name, bc, lat);
        end
        @(negedge clk);
        tests++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_width: got done/busy %b/%b after pulse, required 0/0", name, done8, busy8);
        end
    endtask

    task automatic test_hold_result;
        int bc, lat;
        bit seen;
        drive8(8'hFF, 8'h01, 1'b0, 1);
        tests++;
        if ({busy8, cout8, sum8} !== {1'b1, 1'b0, 8'h7E}) begin
            fails++;
            $display("FAIL hold_prev_result: got busy/cout/sum %b/%b/%h, required 1/0/7e", busy8, cout8, sum8);
        end
        wait_done8(bc, lat, seen);
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL hold_timeout: got no done, required done");
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_and_back_to_back;
        int bc, lat, gap;
        bit seen;
        drive8(8'h10, 8'h20, 1'b0, 1);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        tests++;
        if (busy8 !== 1'b1) begin
            fails++;
            $display("FAIL ignore_busy: got busy %b after start in RUN, required 1", busy8);
        end
        wait_done8(bc, lat, seen);
        tests++;
        if (!seen || lat != 6) begin
            fails++;
            $display("FAIL ignore_timing: got seen %0d latency %0d, required 1 and 6", seen, lat);
        end
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        q8.push_back(9'h003);
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h05; cin8 = 1'b1;
        q8.push_back(9'h046);
        wait_done8(bc, lat, seen);
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL b2b_first_timeout: got no done, required done");
        end
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(bc, lat, seen);
        gap = lat + 1;
        tests++;
        if (!seen || gap != 9) begin
            fails++;
            $display("FAIL b2b_throughput: got seen %0d gap %0d, required 1 and 9", seen, gap);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int bc, lat;
        bit seen, stray;
        drive8(8'h7F, 8'h01, 1'b0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({busy8, done8, cout8, sum8} !== 11'b0) begin
            fails++;
            $display("FAIL midrun_reset: got busy/done/cout/sum %b/%b/%b/%h, required 0/0/0/00", busy8, done8, cout8, sum8);
        end
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 !== 1'b0 || busy8 !== 1'b0) stray = 1;
            @(negedge clk);
        end
        tests++;
        if (stray) begin
            fails++;
            $display("FAIL midrun_no_done: got activity after abandoned run, required idle");
        end
        drive8(8'h7F, 8'h01, 1'b0, 1);
        wait_done8(bc, lat, seen);
        tests++;
        if (!seen || lat != 8) begin
            fails++;
            $display("FAIL midrun_restart: got seen %0d latency %0d, required 1 and 8", seen, lat);
        end
        @(negedge clk);
        start8 = 1'b1; rst = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; rst = 1'b0;
        tests++;
        if ({busy8, sum8} !== 9'b0) begin
            fails++;
            $display("FAIL rst_over_start: got busy/sum %b/%h, required 0/00", busy8, sum8);
        end
    endtask

    task automatic test_width1;
        int bc;
        bit seen;
        drive1(1'b1, 1'b1, 1'b1);
        wait_done1(bc, seen);
        tests++;
        if (!seen || bc != 1 || {cout1, sum1} !== 2'b11) begin
            fails++;
            $display("FAIL w1_ones: got seen %0d busy %0d cout/sum %b/%b, required 1, 1, 1/1", seen, bc, cout1, sum1);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drive1(v[0], v[1], v[2]);
            wait_done1(bc, seen);
            tests++;
            if (!seen || bc != 1) begin
                fails++;
                $display("FAIL w1_sweep_%0d_timing: got seen %0d busy %0d, required 1 and 1", i, seen, bc);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        rst = 1'b1;
        test_reset();
        test_single(8'h00, 8'h00, 1'b0, "zero");
        test_single(8'h3C, 8'h42, 1'b0, "basic");
        test_hold_result();
        test_single(8'hA5, 8'h5A, 1'b1, "carry_chain");
        test_ignore_and_back_to_back();
        test_reset_mid_run();
        test_width1();
        repeat (3) @(negedge clk);
        tests++;
        if (q8.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d/%0d pending results, required 0/0", q8.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
